div_resv_station: RTL and testbench
===================================

Name: div_resv_station

Overview:
- Reservation station feeding the pipelined divider; holds DIV/DIVU/REM/REMU micro-ops from dispatch until both source pregs are ready.
- Issues at most one entry per cycle, always the oldest ready one.
- The divider never stalls, so issue needs no ready handshake.
- Tracks branch masks, squashes on mispredict, and flushes completely on full-pipeline flush.

Parameters:
DEPTH, 4, number of entries (>=2)
PREG_BITS, 6, physical register index width
ROB_BITS, 5, ROB index width
NUM_BRU, 4, branch mask width; BRU_BITS = $clog2(NUM_BRU)
WAKE_PORTS, 3, number of CDB wakeup broadcasts per cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_valid  in  1  dispatch presents a div micro-op
alloc_ready  out  1  station can accept; equals !full (registered count, no same-cycle issue credit)
alloc_ps1, alloc_ps2  in  PREG_BITS each  source pregs
alloc_ps1_rdy, alloc_ps2_rdy  in  1 each  source already valid in regfile
alloc_pd  in  PREG_BITS  destination preg
alloc_rd  in  5  architectural destination
alloc_rob_idx  in  ROB_BITS  ROB slot
alloc_divop  in  3  funct3: 100 div, 101 divu, 110 rem, 111 remu
alloc_br_mask  in  NUM_BRU  outstanding-branch mask
wake_valid  in  WAKE_PORTS  per-port broadcast valid
wake_pd  in  WAKE_PORTS*PREG_BITS  broadcast pregs, port i at [i*PREG_BITS +: PREG_BITS]
br_valid, br_mispred  in  1 each  branch resolution
br_idx  in  BRU_BITS  resolving branch's mask bit
flush  in  1  full flush (exception/recovery)
issue_valid  out  1  entry issued this cycle
issue_ps1, issue_ps2, issue_pd  out  PREG_BITS  to regfile read and divider
issue_rd  out  5;  issue_rob_idx  out  ROB_BITS;  issue_divop  out  3;  issue_br_mask  out  NUM_BRU  fields of issued entry

Behaviour:
- Storage: compacting queue. Entry 0 is oldest. Each entry holds valid, r1, r2, and all alloc fields.
- Reset, or flush: all valid=0 and count=0 next cycle. During reset and in the cycle after it, issue_valid=0 and alloc_ready=1. flush beats a simultaneous alloc, issue, or mispredict.
- Select (combinational from registered state):
  - Pick the lowest index with valid & r1 & r2.
  - issue_valid=1 with that entry's fields.
  - issue_* outputs are don't-care when issue_valid=0.
- Wakeup: any wake port matching ps1 (ps2) sets r1 (r2) at the next edge.
  - Preg 0 is never woken; dispatch marks it ready.
  - Consequence: a woken entry issues no earlier than the cycle after the broadcast.
- Alloc:
  - Accepted when alloc_valid & alloc_ready.
  - Written at the first free slot after compaction of the issued entry.
  - r1/r2 = alloc_psX_rdy OR a same-cycle wake match.
  - Earliest issue is the cycle after alloc.
- Issue removes the entry at the clock edge. Entries above it shift down one, preserving age order.
- Full: count==DEPTH gives alloc_ready=0, even if an issue occurs that cycle.
- Branch, br_valid & br_mispred:
  - Next cycle, invalidate every stored entry and any incoming alloc whose mask bit br_idx is set. Survivors compact.
  - An entry selected in the same cycle is still presented with issue_valid=1; the divider kills it.
- Branch, br_valid & !br_mispred: clear bit br_idx in every stored entry and in the incoming alloc.
- issue_br_mask is the stored mask. The divider clears a same-cycle resolving bit itself.
- Count = popcount of valid after the edge. It must be consistent after combined alloc, issue, and squash in one cycle.

Decomposition:
- Shared package (ooo_config / rv32i_types): PREG_BITS, ROB_BITS, NUM_BRU, BRU_BITS, the div_f3_t enum, and a packed div_rs_entry_t struct.
- One sub-module, rs_oldest_ready_sel: a DEPTH-wide priority encoder returning found and index.

Test Plan:
- Reset, then alloc divu ps1=5 rdy, ps2=6 rdy, pd=9, rob=3 -> issue_valid=1 next cycle with pd=9, rob=3, divop=101. Count returns to 0.
- Alloc A (ps2=7 not ready), then B (both ready) -> B issues first. Wake pd=7 on port 2 -> A issues exactly one cycle after the broadcast.
- Fill 4 non-ready entries -> alloc_ready=0. Wake all in one cycle -> issues in order 0..3 on four consecutive cycles; alloc_ready=1 the cycle after the first issue.
- Entries with masks 0001, 0010, 0011; br_valid, mispred, idx=0 -> only the 0010 entry survives, at slot 0. Count=1.
- Correct prediction idx=1 with the same-cycle alloc of mask 0010 -> the stored entry's mask becomes 0000.
- Alloc with ps1=12 not ready while wake_pd[0]=12 in the same cycle -> entry issues the next cycle. Assert flush with 3 entries -> issue_valid=0 and alloc_ready=1 next cycle.

Source files
------------

// File: rtl/div_resv_station_pkg.sv
// Shared types and widths for the divide reservation station.
package div_resv_station_pkg;
  localparam int PREG_BITS = 6;
  localparam int ROB_BITS  = 5;
  localparam int NUM_BRU   = 4;
  localparam int BRU_BITS  = $clog2(NUM_BRU);

  typedef enum logic [2:0] {
    F3_DIV  = 3'b100,
    F3_DIVU = 3'b101,
    F3_REM  = 3'b110,
    F3_REMU = 3'b111
  } div_f3_t;

  typedef struct packed {
    logic                 valid;
    logic                 r1;
    logic                 r2;
    logic [PREG_BITS-1:0] ps1;
    logic [PREG_BITS-1:0] ps2;
    logic [PREG_BITS-1:0] pd;
    logic [4:0]           rd;
    logic [ROB_BITS-1:0]  rob_idx;
    div_f3_t              divop;
    logic [NUM_BRU-1:0]   br_mask;
  } div_rs_entry_t;
endpackage

// File: rtl/div_resv_station_sel.sv
// Priority encoder: lowest set request bit wins (lowest index = oldest entry).
module rs_oldest_ready_sel #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         req,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);
  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/div_resv_station.sv
// Compacting reservation station for DIV/DIVU/REM/REMU; issues the oldest
// entry whose sources are both ready, one per cycle, with no back-pressure.
module div_resv_station
  import div_resv_station_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int WAKE_PORTS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc_valid,
  output logic                            alloc_ready,
  input  logic [PREG_BITS-1:0]            alloc_ps1,
  input  logic [PREG_BITS-1:0]            alloc_ps2,
  input  logic                            alloc_ps1_rdy,
  input  logic                            alloc_ps2_rdy,
  input  logic [PREG_BITS-1:0]            alloc_pd,
  input  logic [4:0]                      alloc_rd,
  input  logic [ROB_BITS-1:0]             alloc_rob_idx,
  input  logic [2:0]                      alloc_divop,
  input  logic [NUM_BRU-1:0]              alloc_br_mask,
  input  logic [WAKE_PORTS-1:0]           wake_valid,
  input  logic [WAKE_PORTS*PREG_BITS-1:0] wake_pd,
  input  logic                            br_valid,
  input  logic                            br_mispred,
  input  logic [BRU_BITS-1:0]             br_idx,
  input  logic                            flush,
  output logic                            issue_valid,
  output logic [PREG_BITS-1:0]            issue_ps1,
  output logic [PREG_BITS-1:0]            issue_ps2,
  output logic [PREG_BITS-1:0]            issue_pd,
  output logic [4:0]                      issue_rd,
  output logic [ROB_BITS-1:0]             issue_rob_idx,
  output logic [2:0]                      issue_divop,
  output logic [NUM_BRU-1:0]              issue_br_mask
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  div_rs_entry_t    ent_q [DEPTH];
  div_rs_entry_t    ent_d [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [DEPTH-1:0] rdy_vec;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;

  // Preg 0 is hardwired ready at dispatch, so it never matches a broadcast.
  function automatic logic wake_hit(input logic [PREG_BITS-1:0]            p,
                                    input logic [WAKE_PORTS-1:0]           wv,
                                    input logic [WAKE_PORTS*PREG_BITS-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++) begin
      if (wv[k] && (wp[k*PREG_BITS +: PREG_BITS] == p) && (p != '0)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = ent_q[i].valid & ent_q[i].r1 & ent_q[i].r2;
    end
  end

  rs_oldest_ready_sel #(.DEPTH(DEPTH)) u_sel (
    .req   (rdy_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign issue_valid   = sel_found & ~rst;
  assign issue_ps1     = ent_q[sel_idx].ps1;
  assign issue_ps2     = ent_q[sel_idx].ps2;
  assign issue_pd      = ent_q[sel_idx].pd;
  assign issue_rd      = ent_q[sel_idx].rd;
  assign issue_rob_idx = ent_q[sel_idx].rob_idx;
  assign issue_divop   = ent_q[sel_idx].divop;
  assign issue_br_mask = ent_q[sel_idx].br_mask;

  // No credit for a same-cycle issue: full means full.
  assign alloc_ready = rst | (count_q != CNT_W'(DEPTH));

  always_comb begin
    div_rs_entry_t e;
    int            wr;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i]       = ent_q[i];
      ent_d[i].valid = 1'b0;
    end
    wr = 0;
    // Survivors (not issued, not squashed) pack down in age order.
    for (int i = 0; i < DEPTH; i++) begin
      e = ent_q[i];
      if (wake_hit(e.ps1, wake_valid, wake_pd)) e.r1 = 1'b1;
      if (wake_hit(e.ps2, wake_valid, wake_pd)) e.r2 = 1'b1;
      if (br_valid && br_mispred && e.br_mask[br_idx]) e.valid = 1'b0;
      if (br_valid && !br_mispred) e.br_mask[br_idx] = 1'b0;
      if (sel_found && (sel_idx == IDX_W'(i))) e.valid = 1'b0;
      if (e.valid) begin
        ent_d[wr] = e;
        wr        = wr + 1;
      end
    end
    e.valid   = alloc_valid & alloc_ready & ~(br_valid & br_mispred & alloc_br_mask[br_idx]);
    e.r1      = alloc_ps1_rdy | wake_hit(alloc_ps1, wake_valid, wake_pd);
    e.r2      = alloc_ps2_rdy | wake_hit(alloc_ps2, wake_valid, wake_pd);
    e.ps1     = alloc_ps1;
    e.ps2     = alloc_ps2;
    e.pd      = alloc_pd;
    e.rd      = alloc_rd;
    e.rob_idx = alloc_rob_idx;
    e.divop   = div_f3_t'(alloc_divop);
    e.br_mask = alloc_br_mask;
    if (br_valid && !br_mispred) e.br_mask[br_idx] = 1'b0;
    if (e.valid && (wr < DEPTH)) begin
      ent_d[wr] = e;
      wr        = wr + 1;
    end
    count_d = CNT_W'(wr);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_div_resv_station.sv
// Scoreboard bench for div_resv_station against an age-ordered queue model.
module tb_div_resv_station;
  localparam int DEPTH = 4;
  localparam int WP    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [5:0]  alloc_ps1, alloc_ps2, alloc_pd;
  logic        alloc_ps1_rdy, alloc_ps2_rdy;
  logic [4:0]  alloc_rd, alloc_rob_idx;
  logic [2:0]  alloc_divop;
  logic [3:0]  alloc_br_mask;
  logic [2:0]  wake_valid;
  logic [17:0] wake_pd;
  logic        br_valid, br_mispred;
  logic [1:0]  br_idx;
  logic        flush;
  logic        issue_valid;
  logic [5:0]  issue_ps1, issue_ps2, issue_pd;
  logic [4:0]  issue_rd, issue_rob_idx;
  logic [2:0]  issue_divop;
  logic [3:0]  issue_br_mask;

  div_resv_station #(.DEPTH(DEPTH), .WAKE_PORTS(WP)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_ps1(alloc_ps1), .alloc_ps2(alloc_ps2), .alloc_ps1_rdy(alloc_ps1_rdy),
    .alloc_ps2_rdy(alloc_ps2_rdy), .alloc_pd(alloc_pd), .alloc_rd(alloc_rd),
    .alloc_rob_idx(alloc_rob_idx), .alloc_divop(alloc_divop), .alloc_br_mask(alloc_br_mask),
    .wake_valid(wake_valid), .wake_pd(wake_pd), .br_valid(br_valid), .br_mispred(br_mispred),
    .br_idx(br_idx), .flush(flush), .issue_valid(issue_valid), .issue_ps1(issue_ps1),
    .issue_ps2(issue_ps2), .issue_pd(issue_pd), .issue_rd(issue_rd),
    .issue_rob_idx(issue_rob_idx), .issue_divop(issue_divop), .issue_br_mask(issue_br_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ps1, ps2, pd;
    logic [4:0] rd, rob;
    logic [2:0] op;
    logic [3:0] mask;
    bit         r1, r2;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [34:0] fields;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  bit   exp_ready;

  function automatic bit woke(input logic [5:0] p);
    if (p == 6'd0) return 0;
    for (int k = 0; k < WP; k++)
      if (wake_valid[k] && wake_pd[k*6 +: 6] == p) return 1;
    return 0;
  endfunction

  function automatic logic [34:0] pack(input ent_t e);
    return {e.ps1, e.ps2, e.pd, e.rd, e.rob, e.op, e.mask};
  endfunction

  // One clock: publish expectations from the model's current state, then advance it.
  task automatic step();
    int   s;
    ent_t e;
    ent_t nq[$];
    exp_t x;
    s = -1;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) begin s = i; break; end
    exp_ready = rst || (mq.size() != DEPTH);
    if (!rst && s >= 0) begin
      x.cyc = cyc; x.fields = pack(mq[s]);
      exp_q.push_back(x);
    end
    started = 1;
    if (rst || flush) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        if (i == s) continue;
        e = mq[i];
        if (woke(e.ps1)) e.r1 = 1;
        if (woke(e.ps2)) e.r2 = 1;
        if (br_valid && br_mispred && e.mask[br_idx]) continue;
        if (br_valid && !br_mispred) e.mask[br_idx] = 1'b0;
        nq.push_back(e);
      end
      if (alloc_valid && mq.size() < DEPTH &&
          !(br_valid && br_mispred && alloc_br_mask[br_idx])) begin
        e.ps1 = alloc_ps1; e.ps2 = alloc_ps2; e.pd = alloc_pd; e.rd = alloc_rd;
        e.rob = alloc_rob_idx; e.op = alloc_divop; e.mask = alloc_br_mask;
        if (br_valid && !br_mispred) e.mask[br_idx] = 1'b0;
        e.r1 = alloc_ps1_rdy || woke(alloc_ps1);
        e.r2 = alloc_ps2_rdy || woke(alloc_ps2);
        nq.push_back(e);
      end
      mq = nq;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    rst = 0; alloc_valid = 0; alloc_ps1 = 0; alloc_ps2 = 0; alloc_ps1_rdy = 1;
    alloc_ps2_rdy = 1; alloc_pd = 0; alloc_rd = 0; alloc_rob_idx = 0;
    alloc_divop = 3'b100; alloc_br_mask = 0; wake_valid = 0; wake_pd = 0;
    br_valid = 0; br_mispred = 0; br_idx = 0; flush = 0;
  endtask

  task automatic alloc(input logic [5:0] p1, input bit r1, input logic [5:0] p2, input bit r2,
                       input logic [5:0] pd, input logic [4:0] rob, input logic [2:0] op,
                       input logic [3:0] mask);
    alloc_valid = 1; alloc_ps1 = p1; alloc_ps1_rdy = r1; alloc_ps2 = p2; alloc_ps2_rdy = r2;
    alloc_pd = pd; alloc_rd = rob + 5'd1; alloc_rob_idx = rob; alloc_divop = op;
    alloc_br_mask = mask;
  endtask

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (alloc_ready !== exp_ready) begin
        errors++;
        $display("FAIL alloc_ready cyc=%0d got=%b want=%b", cyc, alloc_ready, exp_ready);
      end
      checks++;
      if (issue_valid === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL issue_valid cyc=%0d got=1 want=0", cyc);
        end else begin
          if ({issue_ps1, issue_ps2, issue_pd, issue_rd, issue_rob_idx, issue_divop,
               issue_br_mask} !== exp_q[0].fields) begin
            errors++;
            $display("FAIL issue_fields cyc=%0d got=%h want=%h", cyc,
                     {issue_ps1, issue_ps2, issue_pd, issue_rd, issue_rob_idx, issue_divop,
                      issue_br_mask}, exp_q[0].fields);
          end
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        errors++;
        $display("FAIL issue_valid cyc=%0d got=%b want=1 fields=%h", cyc, issue_valid,
                 exp_q[0].fields);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    step(); step();
    idle();
    step();
    // Single ready divu
    alloc(6'd5, 1, 6'd6, 1, 6'd9, 5'd3, 3'b101, 4'b0000); step();
    idle(); step(); step();
    // Younger ready entry bypasses an older waiting one
    alloc(6'd3, 1, 6'd7, 0, 6'd10, 5'd4, 3'b100, 4'b0000); step();
    alloc(6'd1, 1, 6'd2, 1, 6'd11, 5'd5, 3'b110, 4'b0000); step();
    idle(); step(); step();
    wake_valid = 3'b100; wake_pd = {6'd7, 6'd0, 6'd0}; step();
    idle(); step(); step();
    // Fill, then wake everything at once
    for (int i = 0; i < 4; i++) begin
      alloc(6'd10, 1, 6'd20, 0, 6'(12 + i), 5'(8 + i), 3'b111, 4'b0000); step();
    end
    idle(); step();
    wake_valid = 3'b001; wake_pd = {12'd0, 6'd20}; step();
    idle(); for (int i = 0; i < 6; i++) step();
    // Mispredict squash with compaction
    alloc(6'd1, 1, 6'd30, 0, 6'd40, 5'd1, 3'b100, 4'b0001); step();
    alloc(6'd1, 1, 6'd30, 0, 6'd41, 5'd2, 3'b101, 4'b0010); step();
    alloc(6'd1, 1, 6'd30, 0, 6'd42, 5'd3, 3'b110, 4'b0011); step();
    idle(); br_valid = 1; br_mispred = 1; br_idx = 2'd0; step();
    idle(); step();
    // Correct prediction clears the bit in stored and incoming entries
    alloc(6'd1, 1, 6'd31, 0, 6'd43, 5'd4, 3'b111, 4'b0010);
    br_valid = 1; br_idx = 2'd1; step();
    idle(); step();
    wake_valid = 3'b011; wake_pd = {6'd0, 6'd31, 6'd30}; step();
    idle(); for (int i = 0; i < 4; i++) step();
    // Same-cycle wake at allocation
    alloc(6'd12, 0, 6'd0, 1, 6'd44, 5'd6, 3'b100, 4'b0000);
    wake_valid = 3'b001; wake_pd = {12'd0, 6'd12}; step();
    idle(); step(); step();
    // Flush with three waiting entries
    for (int i = 0; i < 3; i++) begin
      alloc(6'd2, 1, 6'd50, 0, 6'(45 + i), 5'(10 + i), 3'b101, 4'b1000); step();
    end
    idle(); flush = 1; step();
    idle(); wake_valid = 3'b001; wake_pd = {12'd0, 6'd50}; step();
    idle(); step(); step();
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 399) == 0);
      flush = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) != 0) begin
        alloc_valid = 1;
        alloc_ps1 = 6'($urandom_range(0, 15)); alloc_ps2 = 6'($urandom_range(0, 15));
        alloc_ps1_rdy = (alloc_ps1 == 0) || ($urandom_range(0, 1) == 1);
        alloc_ps2_rdy = (alloc_ps2 == 0) || ($urandom_range(0, 1) == 1);
        alloc_pd = 6'($urandom); alloc_rd = 5'($urandom); alloc_rob_idx = 5'($urandom);
        alloc_divop = 3'(3'b100 | 3'($urandom_range(0, 3)));
        alloc_br_mask = 4'($urandom);
      end
      wake_valid = 3'($urandom);
      for (int k = 0; k < WP; k++) wake_pd[k*6 +: 6] = 6'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        br_valid = 1; br_mispred = 1'($urandom); br_idx = 2'($urandom);
      end
      step();
    end
    idle(); flush = 1; step();
    idle(); step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
